// File: rtl/traffic_display_driver_if.sv
// ---------------------------------------------------------------------------
// traffic_display_driver_if
//
// Purpose: bundles the signals between the traffic-light controller side and
// the display driver. The controller side supplies the light state, the
// remaining-seconds count and the 1 Hz tick. The driver side returns the
// multiplexed seven-segment and lamp outputs.
//
// Signals:
//   Tick_1Hz       1-cycle pulse once per second, synchronous to Clock
//   Current_State  light state: RED=00, YELLOW=01, GREEN=10, NONE=11
//   Time_Left      seconds remaining in the current state, 0..15
//   Seg            segments {g,f,e,d,c,b,a}, active-low
//   Digit_En       digit anodes, active-low; bit0 = ones, bit1 = tens
//   Light_R/Y/G    lamp outputs, active-high
//
// Modports:
//   master  controller / board side (drives state, time and tick)
//   slave   display driver (drives segments, anodes and lamps)
// ---------------------------------------------------------------------------
interface traffic_display_driver_if;
    logic       Tick_1Hz;
    logic [1:0] Current_State;
    logic [3:0] Time_Left;
    logic [6:0] Seg;
    logic [1:0] Digit_En;
    logic       Light_R;
    logic       Light_Y;
    logic       Light_G;

    modport master (
        output Tick_1Hz,
        output Current_State,
        output Time_Left,
        input  Seg,
        input  Digit_En,
        input  Light_R,
        input  Light_Y,
        input  Light_G
    );

    modport slave (
        input  Tick_1Hz,
        input  Current_State,
        input  Time_Left,
        output Seg,
        output Digit_En,
        output Light_R,
        output Light_Y,
        output Light_G
    );
endinterface

// File: rtl/traffic_display_driver.sv
// ---------------------------------------------------------------------------
// traffic_display_driver
//
// Purpose: downstream consumer of the traffic-light controller. Shows the
// remaining seconds (00..15, tens digit blanked when zero) on a 2-digit
// multiplexed common-anode seven-segment display and drives the R/Y/G lamps.
// Yellow blinks at 1 Hz. Green blinks once the remaining time drops to
// WARN_TIME or below. Everything runs on the fast system clock; the 1 Hz tick
// is only used as an enable.
//
// Parameters:
//   SCAN_DIV   system-clock cycles each digit is driven before its blank gap
//   WARN_TIME  green starts blinking when Time_q <= WARN_TIME
//
// Ports:
//   Clock  system clock, rising edge
//   Reset  asynchronous, active-high
//   bus    traffic_display_driver_if.slave (inputs from controller,
//          segment/anode/lamp outputs to the board)
// ---------------------------------------------------------------------------
module traffic_display_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int WARN_TIME = 3
) (
    input  logic                           Clock,
    input  logic                           Reset,
    traffic_display_driver_if.slave        bus
);

    // Light-state encodings shared with the controller.
    localparam logic [1:0] ST_RED    = 2'b00;
    localparam logic [1:0] ST_YELLOW = 2'b01;
    localparam logic [1:0] ST_GREEN  = 2'b10;
    localparam logic [1:0] ST_NONE   = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    // The counter only needs to reach SCAN_DIV-1; keep at least one bit so a
    // SCAN_DIV of 1 still elaborates.
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // The scan order is ONES -> GAP1 -> TENS -> GAP0 -> ONES. The gaps blank
    // both anodes for one cycle so the old segment pattern never ghosts onto
    // the newly enabled digit.
    typedef enum logic [1:0] {
        GAP0 = 2'b00,
        ONES = 2'b01,
        GAP1 = 2'b10,
        TENS = 2'b11
    } scan_state_t;

    logic [1:0]       State_q;
    logic [3:0]       Time_q;
    logic             Blink_Phase;

    scan_state_t      Scan_State;
    logic [CNT_W-1:0] Scan_Cnt;

    logic [6:0]       Seg_q;
    logic [1:0]       Digit_En_q;
    logic             Light_R_q;
    logic             Light_Y_q;
    logic             Light_G_q;

    logic             tens_digit;
    logic [3:0]       ones_digit;
    logic [6:0]       ones_pattern;
    logic [6:0]       tens_pattern;
    logic             green_steady;

    // Active-low seven-segment encoding for one decimal digit. Values above 9
    // never reach here because the tens digit has already been split off.
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Capture the controller outputs every cycle so all decoding works from a
    // stable registered copy. A change of light state restarts the blink
    // phase at "lamp on", and that takes priority over a coincident tick so a
    // freshly entered yellow always begins lit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            State_q     <= ST_NONE;
            Time_q      <= 4'd0;
            Blink_Phase <= 1'b0;
        end else begin
            State_q <= bus.Current_State;
            Time_q  <= bus.Time_Left;
            if (State_q != bus.Current_State) begin
                Blink_Phase <= 1'b0;
            end else if (bus.Tick_1Hz) begin
                Blink_Phase <= ~Blink_Phase;
            end
        end
    end

    // Split Time_q (0..15) into a tens flag and a ones digit, then map both
    // to segment patterns. The tens digit is blanked for values below ten,
    // and the NONE state shows a dash on both digits instead of a number.
    always_comb begin
        tens_digit   = (Time_q >= 4'd10);
        ones_digit   = tens_digit ? (Time_q - 4'd10) : Time_q;
        ones_pattern = seg_of(ones_digit);
        tens_pattern = tens_digit ? SEG_ONE : SEG_BLANK;
        if (State_q == ST_NONE) begin
            ones_pattern = SEG_DASH;
            tens_pattern = SEG_DASH;
        end
    end

    // Scan FSM with registered segment/anode outputs. The outputs are loaded
    // for the state being entered, so Digit_En always lines up with
    // Scan_State. The active digit refreshes its pattern every cycle, which
    // gives a two-edge path from Time_Left to Seg (capture, then display).
    // The counter restarts on every transition and the gaps ignore it, so
    // each gap lasts exactly one cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Scan_State <= GAP0;
            Scan_Cnt   <= '0;
            Seg_q      <= SEG_BLANK;
            Digit_En_q <= 2'b11;
        end else begin
            case (Scan_State)
                GAP0: begin
                    Scan_State <= ONES;
                    Scan_Cnt   <= '0;
                    Digit_En_q <= 2'b10;
                    Seg_q      <= ones_pattern;
                end
                ONES: begin
                    if (Scan_Cnt == CNT_LAST) begin
                        Scan_State <= GAP1;
                        Scan_Cnt   <= '0;
                        Digit_En_q <= 2'b11;
                        Seg_q      <= SEG_BLANK;
                    end else begin
                        Scan_Cnt   <= Scan_Cnt + 1'b1;
                        Digit_En_q <= 2'b10;
                        Seg_q      <= ones_pattern;
                    end
                end
                GAP1: begin
                    Scan_State <= TENS;
                    Scan_Cnt   <= '0;
                    Digit_En_q <= 2'b01;
                    Seg_q      <= tens_pattern;
                end
                TENS: begin
                    if (Scan_Cnt == CNT_LAST) begin
                        Scan_State <= GAP0;
                        Scan_Cnt   <= '0;
                        Digit_En_q <= 2'b11;
                        Seg_q      <= SEG_BLANK;
                    end else begin
                        Scan_Cnt   <= Scan_Cnt + 1'b1;
                        Digit_En_q <= 2'b01;
                        Seg_q      <= tens_pattern;
                    end
                end
                default: begin
                    Scan_State <= GAP0;
                    Scan_Cnt   <= '0;
                    Digit_En_q <= 2'b11;
                    Seg_q      <= SEG_BLANK;
                end
            endcase
        end
    end

    // Green stays solid while there is comfortably more than WARN_TIME left.
    assign green_steady = (int'(Time_q) > WARN_TIME);

    // Lamp drive. The state decode guarantees at most one lamp is lit.
    // Blink_Phase=0 means "lit", so both blinking lamps start on.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Light_R_q <= 1'b0;
            Light_Y_q <= 1'b0;
            Light_G_q <= 1'b0;
        end else begin
            Light_R_q <= 1'b0;
            Light_Y_q <= 1'b0;
            Light_G_q <= 1'b0;
            case (State_q)
                ST_RED:    Light_R_q <= 1'b1;
                ST_YELLOW: Light_Y_q <= ~Blink_Phase;
                ST_GREEN:  Light_G_q <= green_steady | ~Blink_Phase;
                default:   ;
            endcase
        end
    end

    assign bus.Seg      = Seg_q;
    assign bus.Digit_En = Digit_En_q;
    assign bus.Light_R  = Light_R_q;
    assign bus.Light_Y  = Light_Y_q;
    assign bus.Light_G  = Light_G_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// ---------------------------------------------------------------------------
// tb_traffic_display_driver
//
// Purpose: directed self-checking bench for traffic_display_driver with
// SCAN_DIV=4 and WARN_TIME=3. The scan repeats every 10 cycles
// (4 ones, 1 gap, 4 tens, 1 gap). The bench counts cycles from reset
// release, so it knows which scan phase to expect on each cycle without
// looking at the DUT.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_traffic_display_driver;

    localparam logic [1:0] ST_RED    = 2'b00;
    localparam logic [1:0] ST_YELLOW = 2'b01;
    localparam logic [1:0] ST_GREEN  = 2'b10;
    localparam logic [1:0] ST_NONE   = 2'b11;

    localparam logic [6:0] P_ZERO  = 7'b1000000;
    localparam logic [6:0] P_ONE   = 7'b1111001;
    localparam logic [6:0] P_FIVE  = 7'b0010010;
    localparam logic [6:0] P_SEVEN = 7'b1111000;
    localparam logic [6:0] P_DASH  = 7'b0111111;
    localparam logic [6:0] P_BLANK = 7'b1111111;

    logic Clock;
    logic Reset;
    int   cyc;
    int   nCompared;
    int   nMismatched;

    traffic_display_driver_if bus ();

    traffic_display_driver #(
        .SCAN_DIV  (4),
        .WARN_TIME (3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // 100 MHz-style free-running clock.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Watchdog so the run always ends even if the stimulus gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock. Everything is sampled and driven 1 time unit after
    // the rising edge.
    task automatic cycle();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [1:0] st, input logic [3:0] t, input logic tk);
        bus.Current_State = st;
        bus.Time_Left     = t;
        bus.Tick_1Hz      = tk;
    endtask

    // One tick pulse, then one more edge so the lamp register reflects it.
    task automatic pulseTick();
        bus.Tick_1Hz = 1'b1;
        cycle();
        bus.Tick_1Hz = 1'b0;
        cycle();
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expSeg, input logic [1:0] expEn);
        nCompared++;
        assert ({bus.Seg, bus.Digit_En} === {expSeg, expEn}) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed Seg=%b Digit_En=%b, expected Seg=%b Digit_En=%b",
                   tag, bus.Seg, bus.Digit_En, expSeg, expEn);
        end
    endtask

    task automatic checkLamps(input string tag, input logic r, input logic y, input logic g);
        nCompared++;
        assert ({bus.Light_R, bus.Light_Y, bus.Light_G} === {r, y, g}) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed RYG=%b%b%b, expected RYG=%b%b%b",
                   tag, bus.Light_R, bus.Light_Y, bus.Light_G, r, y, g);
        end
    endtask

    // Expected scan outputs from the position within the 10-cycle frame.
    // Cycle 1 after release is the first ONES cycle.
    task automatic checkPos(input string tag, input logic [6:0] onesPat, input logic [6:0] tensPat);
        int         p;
        logic [6:0] s;
        logic [1:0] e;
        p = (cyc - 1) % 10;
        if (p < 4) begin
            e = 2'b10;
            s = onesPat;
        end else if (p == 4 || p == 9) begin
            e = 2'b11;
            s = P_BLANK;
        end else begin
            e = 2'b01;
            s = tensPat;
        end
        checkOutput($sformatf("%s_p%0d", tag, p), s, e);
    endtask

    task automatic waitPos(input int p);
        for (int i = 0; i < 12; i++) begin
            if (cyc >= 1 && ((cyc - 1) % 10) == p) break;
            cycle();
        end
    endtask

    task automatic releaseReset();
        Reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        cyc         = 0;
        Reset       = 1'b1;
        applyStimulus(ST_GREEN, 4'd15, 1'b0);
        cycle();
        cycle();
        cycle();

        // Reset values, then GREEN 15 over one full scan frame.
        releaseReset();
        checkOutput("reset_seg", P_BLANK, 2'b11);
        checkLamps("reset_lamps", 1'b0, 1'b0, 1'b0);
        cycle();
        checkOutput("first_ones_none", P_DASH, 2'b10);
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkPos("green15", P_FIVE, P_ONE);
        end
        checkLamps("green15_lamps", 1'b0, 1'b0, 1'b1);

        // Reset asserted in the middle of TENS.
        waitPos(6);
        checkOutput("pre_reset_tens", P_ONE, 2'b01);
        Reset = 1'b1;
        #1;
        checkOutput("async_reset_seg", P_BLANK, 2'b11);
        checkLamps("async_reset_lamps", 1'b0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        releaseReset();
        checkOutput("post_reset_gap", P_BLANK, 2'b11);
        cycle();
        checkOutput("post_reset_ones0", P_DASH, 2'b10);
        for (int i = 1; i < 4; i++) begin
            cycle();
            checkOutput($sformatf("post_reset_ones%0d", i), P_FIVE, 2'b10);
        end
        cycle();
        checkOutput("post_reset_gap1", P_BLANK, 2'b11);

        // RED 7: tens digit blanked.
        applyStimulus(ST_RED, 4'd7, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkPos("red7", P_SEVEN, P_BLANK);
        end
        checkLamps("red7_lamps", 1'b1, 1'b0, 1'b0);

        // RED 10: boundary where the tens digit first appears.
        applyStimulus(ST_RED, 4'd10, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkPos("red10", P_ZERO, P_ONE);
        end

        // GREEN then YELLOW with a coincident tick: the state change wins.
        applyStimulus(ST_GREEN, 4'd15, 1'b0);
        cycle();
        cycle();
        cycle();
        checkLamps("green_before_yellow", 1'b0, 1'b0, 1'b1);
        applyStimulus(ST_YELLOW, 4'd15, 1'b1);
        cycle();
        bus.Tick_1Hz = 1'b0;
        cycle();
        checkLamps("yellow_entry", 1'b0, 1'b1, 1'b0);
        pulseTick();
        checkLamps("yellow_tick1", 1'b0, 1'b0, 1'b0);
        pulseTick();
        checkLamps("yellow_tick2", 1'b0, 1'b1, 1'b0);
        pulseTick();
        checkLamps("yellow_tick3", 1'b0, 1'b0, 1'b0);

        // GREEN countdown into the warning window.
        applyStimulus(ST_GREEN, 4'd5, 1'b0);
        cycle();
        cycle();
        checkLamps("green_t5", 1'b0, 1'b0, 1'b1);
        applyStimulus(ST_GREEN, 4'd4, 1'b1);
        cycle();
        bus.Tick_1Hz = 1'b0;
        cycle();
        checkLamps("green_t4", 1'b0, 1'b0, 1'b1);
        applyStimulus(ST_GREEN, 4'd3, 1'b1);
        cycle();
        bus.Tick_1Hz = 1'b0;
        cycle();
        checkLamps("green_t3", 1'b0, 1'b0, 1'b1);
        pulseTick();
        checkLamps("green_t3_tick", 1'b0, 1'b0, 1'b0);
        applyStimulus(ST_GREEN, 4'd2, 1'b1);
        cycle();
        bus.Tick_1Hz = 1'b0;
        cycle();
        checkLamps("green_t2", 1'b0, 1'b0, 1'b1);
        pulseTick();
        checkLamps("green_t2_tick", 1'b0, 1'b0, 1'b0);

        // NONE: dashes on both digits, lamps dark through ticks.
        applyStimulus(ST_NONE, 4'd9, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkPos("none", P_DASH, P_DASH);
        end
        checkLamps("none_lamps", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulseTick();
            checkLamps($sformatf("none_tick%0d", i + 1), 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
